// File: rtl/ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module  : ahb2apb_bridge
// Brief   : AHB-Lite slave that turns single AHB transfers into APB transfers.
// Revision: 1.0 - initial release
// ============================================================================
module ahb2apb_bridge #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int NUM_PSEL   = 4,
    parameter int DEC_LSB    = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic [HADDR_SIZE-1:0] PADDR,
    output logic                  PWRITE,
    output logic [HDATA_SIZE-1:0] PWDATA,
    output logic [NUM_PSEL-1:0]   PSEL,
    output logic                  PENABLE,
    input  logic [HDATA_SIZE-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int IDX_W = $clog2(NUM_PSEL);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WLATCH = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    state_t                  w_accept_state;
    logic [HADDR_SIZE-1:0]   r_paddr;
    logic                    r_pwrite;
    logic [HDATA_SIZE-1:0]   r_pwdata;
    logic [IDX_W-1:0]        r_idx;
    logic                    w_accept;
    logic                    w_illegal;
    logic                    w_apb_ok;
    logic                    w_open;
    logic                    w_load;
    logic                    w_unused;

    // HBURST and the SEQ/NONSEQ distinction have no effect: every beat is a single.
    assign w_unused = &{1'b0, HBURST, HTRANS[0]};

    assign w_accept  = HSEL && HREADY && HTRANS[1];
    assign w_illegal = (HSIZE > 3'd2)
                    || ((HSIZE == 3'd1) && HADDR[0])
                    || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign w_apb_ok  = (r_state == S_ACCESS) && PREADY && !PSLVERR;
    // Slots in which a new address phase may be taken (bridge drives HREADYOUT=1).
    assign w_open    = (r_state == S_IDLE) || (r_state == S_ERR2) || w_apb_ok;
    assign w_load    = w_open && w_accept;

    always_comb begin
        w_accept_state = S_IDLE;
        if (w_accept) begin
            if (w_illegal)   w_accept_state = S_ERR1;
            else if (HWRITE) w_accept_state = S_WLATCH;
            else             w_accept_state = S_SETUP;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state  <= S_IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_idx    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_paddr  <= HADDR;
                r_pwrite <= HWRITE;
                r_idx    <= HADDR[DEC_LSB +: IDX_W];
            end
            if (r_state == S_WLATCH) begin
                r_pwdata <= HWDATA;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        HRDATA      = '0;
        PSEL        = '0;
        PENABLE     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = w_accept_state;
            end
            S_WLATCH: begin
                HREADYOUT   = 1'b0;
                w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                HREADYOUT   = 1'b0;
                PSEL        = NUM_PSEL'(1) << r_idx;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = NUM_PSEL'(1) << r_idx;
                PENABLE = 1'b1;
                if (!PREADY) begin
                    HREADYOUT = 1'b0;
                end else if (PSLVERR) begin
                    HREADYOUT   = 1'b0;
                    w_state_nxt = S_ERR1;
                end else begin
                    if (!r_pwrite) HRDATA = PRDATA;
                    w_state_nxt = w_accept_state;
                end
            end
            S_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                HRESP       = 1'b1;
                w_state_nxt = w_accept_state;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign PADDR  = r_paddr;
    assign PWRITE = r_pwrite;
    assign PWDATA = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb2apb_bridge
// Brief   : Directed self-checking bench for ahb2apb_bridge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb2apb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        r_hready_en;

    int n_tot = 0;
    int n_bad = 0;

    // System HREADY follows the bridge unless another slave is modelled as stalling.
    assign HREADY = HREADYOUT & r_hready_en;

    ahb2apb_bridge #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .NUM_PSEL(4), .DEC_LSB(12)
    ) u_dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [1:0] t,
                              input logic [2:0] s);
        HSEL = 1'b1; HADDR = a; HWRITE = w; HTRANS = t; HSIZE = s;
    endtask

    task automatic no_xfer();
        HTRANS = 2'd0; HSEL = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'd0;
        HSIZE = 3'd2; HBURST = 3'd0; HWDATA = '0; PRDATA = '0; PREADY = 1'b1;
        PSLVERR = 1'b0; r_hready_en = 1'b1;
        #12;
        chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("rst_hresp",     {31'd0, HRESP},     32'd0);
        chk("rst_hrdata",    HRDATA,             32'd0);
        chk("rst_psel",      {28'd0, PSEL},      32'd0);
        chk("rst_penable",   {31'd0, PENABLE},   32'd0);
        chk("rst_paddr",     PADDR,              32'd0);
        chk("rst_pwdata",    PWDATA,             32'd0);
        chk("rst_pwrite",    {31'd0, PWRITE},    32'd0);
        step(); HRESET = 1'b0;

        // Zero-wait write 0xDEADBEEF to 0x2004
        step(); addr_phase(32'h2004, 1'b1, 2'd2, 3'd2); settle();
        chk("wr_addr_rdy", {31'd0, HREADYOUT}, 32'd1);
        step(); no_xfer(); HWDATA = 32'hDEADBEEF; settle();
        chk("wr_wlatch_rdy",  {31'd0, HREADYOUT}, 32'd0);
        chk("wr_wlatch_psel", {28'd0, PSEL},      32'd0);
        step(); HWDATA = 32'h0; settle();
        chk("wr_setup_rdy",   {31'd0, HREADYOUT}, 32'd0);
        chk("wr_setup_psel",  {28'd0, PSEL},      32'h4);
        chk("wr_setup_pen",   {31'd0, PENABLE},   32'd0);
        chk("wr_paddr",       PADDR,              32'h2004);
        chk("wr_pwdata",      PWDATA,             32'hDEADBEEF);
        chk("wr_pwrite",      {31'd0, PWRITE},    32'd1);
        step(); settle();
        chk("wr_access_pen",  {31'd0, PENABLE},   32'd1);
        chk("wr_access_rdy",  {31'd0, HREADYOUT}, 32'd1);
        chk("wr_access_resp", {31'd0, HRESP},     32'd0);
        chk("wr_access_hrd",  HRDATA,             32'd0);
        step(); settle();
        chk("wr_done_psel",   {28'd0, PSEL},      32'd0);
        chk("wr_done_pwdata", PWDATA,             32'hDEADBEEF);

        // Read 0x3000 with three APB wait states
        addr_phase(32'h3000, 1'b0, 2'd2, 3'd2); settle();
        step(); no_xfer(); PREADY = 1'b0; PRDATA = 32'h12345678; settle();
        chk("rd_setup_rdy",  {31'd0, HREADYOUT}, 32'd0);
        chk("rd_setup_psel", {28'd0, PSEL},      32'h8);
        chk("rd_setup_hrd",  HRDATA,             32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            chk("rd_wait_rdy", {31'd0, HREADYOUT}, 32'd0);
            chk("rd_wait_pen", {31'd0, PENABLE},   32'd1);
            chk("rd_wait_hrd", HRDATA,             32'd0);
        end
        step(); PREADY = 1'b1; settle();
        chk("rd_done_rdy", {31'd0, HREADYOUT}, 32'd1);
        chk("rd_done_hrd", HRDATA,             32'h12345678);
        chk("rd_paddr",    PADDR,              32'h3000);
        step(); settle();
        chk("rd_idle_hrd",  HRDATA,        32'd0);
        chk("rd_idle_psel", {28'd0, PSEL}, 32'd0);

        // APB slave error on read 0x1000
        addr_phase(32'h1000, 1'b0, 2'd2, 3'd2); settle();
        step(); no_xfer(); settle();
        chk("err_setup_psel", {28'd0, PSEL}, 32'h2);
        step(); PSLVERR = 1'b1; settle();
        chk("err_access_rdy",  {31'd0, HREADYOUT}, 32'd0);
        chk("err_access_resp", {31'd0, HRESP},     32'd0);
        step(); PSLVERR = 1'b0; settle();
        chk("err1_resp", {31'd0, HRESP},     32'd1);
        chk("err1_rdy",  {31'd0, HREADYOUT}, 32'd0);
        chk("err1_psel", {28'd0, PSEL},      32'd0);
        step(); settle();
        chk("err2_resp", {31'd0, HRESP},     32'd1);
        chk("err2_rdy",  {31'd0, HREADYOUT}, 32'd1);
        step(); settle();
        chk("err_idle_resp", {31'd0, HRESP},     32'd0);
        chk("err_idle_rdy",  {31'd0, HREADYOUT}, 32'd1);

        // Illegal transfers: misaligned word, then oversize
        for (int k = 0; k < 2; k++) begin
            if (k == 0) addr_phase(32'h1002, 1'b0, 2'd2, 3'd2);
            else        addr_phase(32'h1000, 1'b1, 2'd2, 3'd3);
            settle();
            step(); no_xfer(); settle();
            chk("ill_err1_resp", {31'd0, HRESP},     32'd1);
            chk("ill_err1_rdy",  {31'd0, HREADYOUT}, 32'd0);
            chk("ill_err1_psel", {28'd0, PSEL},      32'd0);
            step(); settle();
            chk("ill_err2_resp", {31'd0, HRESP},     32'd1);
            chk("ill_err2_rdy",  {31'd0, HREADYOUT}, 32'd1);
            chk("ill_err2_psel", {28'd0, PSEL},      32'd0);
            step(); settle();
            chk("ill_idle_resp", {31'd0, HRESP},     32'd0);
        end

        // Back-to-back: read 0x0000 then SEQ write 0x1008 on the completing edge
        addr_phase(32'h0000, 1'b0, 2'd2, 3'd2); settle();
        step(); no_xfer(); PRDATA = 32'hA5A5A5A5; settle();
        chk("b2b_setup_psel", {28'd0, PSEL}, 32'h1);
        step(); addr_phase(32'h1008, 1'b1, 2'd3, 3'd2); settle();
        chk("b2b_rd_rdy", {31'd0, HREADYOUT}, 32'd1);
        chk("b2b_rd_hrd", HRDATA,             32'hA5A5A5A5);
        step(); no_xfer(); HWDATA = 32'hCAFEF00D; settle();
        chk("b2b_wlatch_rdy",  {31'd0, HREADYOUT}, 32'd0);
        chk("b2b_wlatch_psel", {28'd0, PSEL},      32'd0);
        step(); settle();
        chk("b2b_setup2_psel", {28'd0, PSEL}, 32'h2);
        chk("b2b_paddr",       PADDR,         32'h1008);
        chk("b2b_pwdata",      PWDATA,        32'hCAFEF00D);
        step(); settle();
        chk("b2b_access_pen", {31'd0, PENABLE},   32'd1);
        chk("b2b_access_rdy", {31'd0, HREADYOUT}, 32'd1);
        chk("b2b_access_hrd", HRDATA,             32'd0);
        step(); settle();

        // BUSY while selected: zero-wait OKAY, no APB activity
        addr_phase(32'h2000, 1'b0, 2'd1, 3'd2); settle();
        chk("busy_rdy", {31'd0, HREADYOUT}, 32'd1);
        step(); settle();
        chk("busy_next_rdy",  {31'd0, HREADYOUT}, 32'd1);
        chk("busy_next_psel", {28'd0, PSEL},      32'd0);
        chk("busy_next_resp", {31'd0, HRESP},     32'd0);

        // System HREADY low blocks acceptance
        r_hready_en = 1'b0; addr_phase(32'h3000, 1'b0, 2'd2, 3'd2); settle();
        step(); no_xfer(); r_hready_en = 1'b1; settle();
        chk("hrdy_block_rdy",  {31'd0, HREADYOUT}, 32'd1);
        chk("hrdy_block_psel", {28'd0, PSEL},      32'd0);

        // Asynchronous reset during a stalled ACCESS
        addr_phase(32'h3000, 1'b0, 2'd2, 3'd2); settle();
        step(); no_xfer(); PREADY = 1'b0; settle();
        step(); settle();
        chk("arst_pre_pen", {31'd0, PENABLE}, 32'd1);
        #2 HRESET = 1'b1;
        #1;
        chk("arst_psel", {28'd0, PSEL},      32'd0);
        chk("arst_pen",  {31'd0, PENABLE},   32'd0);
        chk("arst_rdy",  {31'd0, HREADYOUT}, 32'd1);
        chk("arst_resp", {31'd0, HRESP},     32'd0);
        step(); HRESET = 1'b0; PREADY = 1'b1;
        step(); settle();
        chk("arst_idle_psel", {28'd0, PSEL},      32'd0);
        chk("arst_idle_rdy",  {31'd0, HREADYOUT}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
